// File: rtl/mem_access_unit.sv
// mem_access_unit: byte-addressed load/store front end for a word-addressed
// data memory. Handles sub-word read-modify-write stores, sub-word load
// extraction with sign/zero extension, and misaligned-access rejection.
// Optional build macro: MEMACC_STATS_EN adds saturating load/store/error
// counters (stat_loads, stat_stores, stat_errors).
module mem_access_unit #(
    parameter int addresswidth = 32,
    parameter bit big_endian   = 1'b1,
    parameter int count_width  = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [1:0]              req_size,
    input  logic                    req_unsigned,
    input  logic [addresswidth-1:0] req_addr,
    input  logic [31:0]             req_wdata,
    output logic                    resp_valid,
    output logic [31:0]             resp_rdata,
    output logic                    resp_err,
    output logic [addresswidth-1:0] mem_address,
    output logic                    mem_write_en,
    output logic                    mem_read_en,
    output logic [31:0]             mem_data_in,
    input  logic [31:0]             mem_data_out
`ifdef MEMACC_STATS_EN
    ,
    output logic [count_width-1:0]  stat_loads,
    output logic [count_width-1:0]  stat_stores,
    output logic [count_width-1:0]  stat_errors
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [addresswidth-1:0] addr_r;
    logic [1:0]              size_r;
    logic                    write_r;
    logic                    unsigned_r;
    logic [31:0]             wdata_r;
    logic                    err_r;
    logic [31:0]             word_r;
    logic                    accept_s;
    logic                    misalign_s;

    // Bit position of the low end of a byte lane within the memory word.
    function automatic logic [4:0] byte_shift(input logic [1:0] off);
        logic [1:0] lane;
        lane = big_endian ? (2'd3 - off) : off;
        return {lane, 3'b000};
    endfunction

    // Bit position of the low end of a halfword lane within the memory word.
    function automatic logic [4:0] half_shift(input logic hoff);
        logic lane;
        lane = big_endian ? ~hoff : hoff;
        return {lane, 4'b0000};
    endfunction

    // Replace only the addressed lane of the old word with the store data.
    function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                               input logic [31:0] data,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off);
        logic [4:0]  sh;
        logic [31:0] mask;
        case (size)
            SZ_BYTE: begin
                sh   = byte_shift(off);
                mask = 32'h0000_00FF << sh;
                return (old_word & ~mask) | ((data & 32'h0000_00FF) << sh);
            end
            SZ_HALF: begin
                sh   = half_shift(off[1]);
                mask = 32'h0000_FFFF << sh;
                return (old_word & ~mask) | ((data & 32'h0000_FFFF) << sh);
            end
            default: return data;
        endcase
    endfunction

    // Pull the addressed lane down to the low bits and extend it.
    function automatic logic [31:0] extract_load(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  off,
                                                 input logic        uns);
        logic [31:0] shifted;
        case (size)
            SZ_BYTE: begin
                shifted = word >> byte_shift(off);
                return {{24{~uns & shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                shifted = word >> half_shift(off[1]);
                return {{16{~uns & shifted[15]}}, shifted[15:0]};
            end
            default: return word;
        endcase
    endfunction

    assign accept_s = req_valid && (state_r == ST_IDLE);

    // Classify the incoming request as misaligned or reserved-size.
    always_comb begin
        misalign_s = 1'b0;
        case (req_size)
            SZ_BYTE: misalign_s = 1'b0;
            SZ_HALF: misalign_s = req_addr[0];
            SZ_WORD: misalign_s = (req_addr[1:0] != 2'b00);
            default: misalign_s = 1'b1;
        endcase
    end

    // State register; reset forces IDLE immediately so memory enables drop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (misalign_s) begin
                        state_nxt_s = ST_RESP;
                    end else if (req_write && (req_size == SZ_WORD)) begin
                        state_nxt_s = ST_WR;
                    end else begin
                        state_nxt_s = ST_RD;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RD: begin
                if (write_r) begin
                    state_nxt_s = ST_WR;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            ST_WR:   state_nxt_s = ST_RESP;
            ST_RESP: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Latch request fields on acceptance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_r     <= '0;
            size_r     <= 2'b00;
            write_r    <= 1'b0;
            unsigned_r <= 1'b0;
            wdata_r    <= 32'h0000_0000;
            err_r      <= 1'b0;
        end else if (accept_s) begin
            addr_r     <= req_addr;
            size_r     <= req_size;
            write_r    <= req_write;
            unsigned_r <= req_unsigned;
            wdata_r    <= req_wdata;
            err_r      <= misalign_s;
        end
    end

    // Capture the memory word at the end of the read cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_r <= 32'h0000_0000;
        end else if (state_r == ST_RD) begin
            word_r <= mem_data_out;
        end
    end

    assign mem_address = {2'b00, addr_r[addresswidth-1:2]};

    // Moore output decode from state and latched fields.
    always_comb begin
        req_ready    = 1'b0;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        mem_data_in  = 32'h0000_0000;
        resp_valid   = 1'b0;
        resp_err     = 1'b0;
        resp_rdata   = 32'h0000_0000;
        case (state_r)
            ST_IDLE: req_ready = 1'b1;
            ST_RD:   mem_read_en = 1'b1;
            ST_WR: begin
                mem_write_en = 1'b1;
                mem_data_in  = merge_word(word_r, wdata_r, size_r, addr_r[1:0]);
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_r;
                if (!err_r && !write_r) begin
                    resp_rdata = extract_load(word_r, size_r, addr_r[1:0], unsigned_r);
                end else begin
                    resp_rdata = 32'h0000_0000;
                end
            end
            default: req_ready = 1'b0;
        endcase
    end

`ifdef MEMACC_STATS_EN
    localparam logic [count_width-1:0] CNT_MAX = {count_width{1'b1}};
    localparam logic [count_width-1:0] CNT_ONE = {{(count_width-1){1'b0}}, 1'b1};

    // Saturating completion counters, bumped in the response cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_loads  <= '0;
            stat_stores <= '0;
            stat_errors <= '0;
        end else if (state_r == ST_RESP) begin
            if (err_r) begin
                if (stat_errors != CNT_MAX) stat_errors <= stat_errors + CNT_ONE;
            end else if (write_r) begin
                if (stat_stores != CNT_MAX) stat_stores <= stat_stores + CNT_ONE;
            end else begin
                if (stat_loads != CNT_MAX) stat_loads <= stat_loads + CNT_ONE;
            end
        end
    end
`else
    // Counter width is only meaningful with statistics enabled.
    logic [count_width-1:0] stats_unused_s;
    assign stats_unused_s = '0;
`endif

endmodule
